present_round_ctrl: RTL

- Iterative PRESENT-80 encryption controller that sequences the 64-bit datapath: addRoundKey, then sLayer, then the existing PLayer (instantiated, ports original/permuted).
- Runs one round per clock over 31 rounds, runs the 80-bit key schedule in parallel, and applies a final key whitening.
- Sits between the block-input interface and the ciphertext consumer, using valid/ready handshakes on both sides.

---
 rtl/present_round_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/present_round_ctrl.sv
// Iterative PRESENT-80 encryption controller: one round per clock, key schedule
// in parallel, final key whitening, valid/ready handshakes on both sides.

module PLayer (
  input  logic [63:0] original,
  output logic [63:0] permuted
);
  // Bit i moves to position i*16 mod 63; bit 63 stays in place.
  for (genvar i = 0; i < 63; i++) begin : g_perm
    assign permuted[(i * 16) % 63] = original[i];
  end
  assign permuted[63] = original[63];
endmodule

module present_round_ctrl #(
  parameter int NUM_ROUNDS = 31,
  parameter int ROUND_W    = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [63:0]        in_plain,
  input  logic [79:0]        in_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [63:0]        out_cipher,
  output logic               busy,
  output logic [ROUND_W-1:0] round_idx
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} fsm_t;

  fsm_t        r_fsm;
  logic [63:0] r_state;
  logic [79:0] r_key;

  logic [63:0] w_xk;
  logic [63:0] w_sub;
  logic [63:0] w_perm;
  logic [79:0] w_key_rot;
  logic [79:0] w_key_next;
  logic [4:0]  w_rc;
  logic        w_last;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0:    y = 4'hC;
      4'h1:    y = 4'h5;
      4'h2:    y = 4'h6;
      4'h3:    y = 4'hB;
      4'h4:    y = 4'h9;
      4'h5:    y = 4'h0;
      4'h6:    y = 4'hA;
      4'h7:    y = 4'hD;
      4'h8:    y = 4'h3;
      4'h9:    y = 4'hE;
      4'hA:    y = 4'hF;
      4'hB:    y = 4'h8;
      4'hC:    y = 4'h4;
      4'hD:    y = 4'h7;
      4'hE:    y = 4'h1;
      4'hF:    y = 4'h2;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  assign w_xk = r_state ^ r_key[79:16];

  for (genvar n = 0; n < 16; n++) begin : g_sbox
    assign w_sub[4*n +: 4] = sbox4(w_xk[4*n +: 4]);
  end

  PLayer u_player (
    .original (w_sub),
    .permuted (w_perm)
  );

  // The round constant is always 5 bits wide; wider counters contribute only their low bits.
  if (ROUND_W >= 5) begin : g_rc_trunc
    assign w_rc = round_idx[4:0];
  end else begin : g_rc_ext
    assign w_rc = {{(5 - ROUND_W){1'b0}}, round_idx};
  end

  assign w_key_rot  = {r_key[18:0], r_key[79:19]};
  assign w_key_next = {sbox4(w_key_rot[79:76]), w_key_rot[75:20],
                       w_key_rot[19:15] ^ w_rc, w_key_rot[14:0]};
  assign w_last     = (round_idx == ROUND_W'(NUM_ROUNDS));

  // Control FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm      <= S_IDLE;
      r_state    <= 64'd0;
      r_key      <= 80'd0;
      round_idx  <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_cipher <= 64'd0;
      busy       <= 1'b0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (in_valid) begin
            r_state   <= in_plain;
            r_key     <= in_key;
            round_idx <= ROUND_W'(1);
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            r_fsm     <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_state <= w_perm;
          r_key   <= w_key_next;
          // The counter stops at NUM_ROUNDS rather than wrapping.
          if (w_last) begin
            r_fsm <= S_FINAL;
          end else begin
            round_idx <= round_idx + ROUND_W'(1);
          end
        end
        S_FINAL: begin
          out_cipher <= w_xk;
          out_valid  <= 1'b1;
          busy       <= 1'b0;
          r_fsm      <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            round_idx <= '0;
            in_ready  <= 1'b1;
            r_fsm     <= S_IDLE;
          end
        end
        default: begin
          r_fsm      <= S_IDLE;
          r_state    <= 64'd0;
          r_key      <= 80'd0;
          round_idx  <= '0;
          in_ready   <= 1'b1;
          out_valid  <= 1'b0;
          out_cipher <= 64'd0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
